// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: keeps the board, alternates turns, rejects illegal moves,
// and resolves win/draw from the external three-in-a-row checker.
`timescale 1ns/1ps
module ttt_move_ctrl #(
    parameter bit FIRST_PLAYER = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        mv_valid,
    input  logic [3:0]  mv_cell,
    input  logic        win_in,
    output logic [17:0] board,
    output logic [17:0] chk_board,
    output logic        turn,
    output logic        mv_ready,
    output logic        mv_ack,
    output logic        mv_err,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [3:0]  move_cnt
);

    typedef enum logic [1:0] {StPlay, StCheck, StWin, StDraw} state_e;

    state_e      state;
    logic [1:0]  mover_code;
    logic        target_busy;
    logic [17:0] board_wr;

    assign mover_code = {turn, ~turn};
    assign mv_ready   = (state == StPlay);

    // Out-of-range cells never match the loop, so they stay "busy" and are rejected.
    always_comb begin
        target_busy = 1'b1;
        board_wr    = board;
        for (int i = 0; i < 9; i++) begin
            if (mv_cell == 4'(i)) begin
                target_busy            = |board[17-2*i -: 2];
                board_wr[17-2*i -: 2] = mover_code;
            end
        end
    end

    // Only the mover's cells are shown, so the occupancy checker sees just their lines.
    always_comb begin
        chk_board = '0;
        for (int i = 0; i < 9; i++) begin
            chk_board[17-2*i -: 2] = (board[17-2*i -: 2] == mover_code) ? 2'b01 : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state     <= StPlay;
            board     <= '0;
            move_cnt  <= '0;
            turn      <= FIRST_PLAYER;
            winner    <= 2'b00;
            game_over <= 1'b0;
            mv_ack    <= 1'b0;
            mv_err    <= 1'b0;
        end else begin
            mv_ack <= 1'b0;
            mv_err <= 1'b0;
            unique case (state)
                StPlay: begin
                    if (mv_valid) begin
                        if (target_busy) begin
                            mv_err <= 1'b1;
                        end else begin
                            board    <= board_wr;
                            move_cnt <= move_cnt + 4'd1;
                            mv_ack   <= 1'b1;
                            state    <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (win_in) begin
                        state     <= StWin;
                        winner    <= mover_code;
                        game_over <= 1'b1;
                    end else if (move_cnt == 4'd9) begin
                        state     <= StDraw;
                        winner    <= 2'b00;
                        game_over <= 1'b1;
                    end else begin
                        turn  <= ~turn;
                        state <= StPlay;
                    end
                end
                StWin, StDraw: begin
                end
                default: state <= StPlay;
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Bench for ttt_move_ctrl: two instances (X first, O first) run the same moves against a
// cell-array game model, plus literal expectations from hand-worked games.
`timescale 1ns/1ps
module tb_ttt_move_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       new_game = 1'b0;
    logic       mv_valid = 1'b0;
    logic [3:0] mv_cell = 4'd0;

    logic [17:0] board_w[2];
    logic [17:0] chk_w[2];
    logic        turn_w[2];
    logic        ready_w[2];
    logic        ack_w[2];
    logic        err_w[2];
    logic        over_w[2];
    logic [1:0]  winner_w[2];
    logic [3:0]  cnt_w[2];
    logic        win_w[2];

    int n_vec = 0;
    int n_err = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    bit armed = 0;

    int lines[8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                        '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

    always #5 clk = ~clk;

    // Reference checker: any full line of occupied cells in the feed.
    function automatic logic line_win(logic [17:0] b);
        for (int l = 0; l < 8; l++) begin
            if (b[16-2*lines[l][0]] && b[16-2*lines[l][1]] && b[16-2*lines[l][2]])
                return 1'b1;
        end
        return 1'b0;
    endfunction

    assign win_w[0] = line_win(chk_w[0]);
    assign win_w[1] = line_win(chk_w[1]);

    ttt_move_ctrl #(.FIRST_PLAYER(1'b0)) dut0 (
        .clk(clk), .rst(rst), .new_game(new_game), .mv_valid(mv_valid), .mv_cell(mv_cell),
        .win_in(win_w[0]), .board(board_w[0]), .chk_board(chk_w[0]), .turn(turn_w[0]),
        .mv_ready(ready_w[0]), .mv_ack(ack_w[0]), .mv_err(err_w[0]), .game_over(over_w[0]),
        .winner(winner_w[0]), .move_cnt(cnt_w[0])
    );

    ttt_move_ctrl #(.FIRST_PLAYER(1'b1)) dut1 (
        .clk(clk), .rst(rst), .new_game(new_game), .mv_valid(mv_valid), .mv_cell(mv_cell),
        .win_in(win_w[1]), .board(board_w[1]), .chk_board(chk_w[1]), .turn(turn_w[1]),
        .mv_ready(ready_w[1]), .mv_ack(ack_w[1]), .mv_err(err_w[1]), .game_over(over_w[1]),
        .winner(winner_w[1]), .move_cnt(cnt_w[1])
    );

    // Game model: cells hold 0 empty, 1 X, 2 O; phase 0 play, 1 check, 2 win, 3 draw.
    int m_cells[2][9];
    bit m_turn[2];
    int m_cnt[2];
    int m_phase[2];
    int m_winner[2];
    bit m_ack[2];
    bit m_err[2];
    bit fp[2] = '{1'b0, 1'b1};

    function automatic bit has_line(int k, int code);
        for (int l = 0; l < 8; l++) begin
            if (m_cells[k][lines[l][0]] == code && m_cells[k][lines[l][1]] == code &&
                m_cells[k][lines[l][2]] == code)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || new_game) begin
                for (int n = 0; n < 9; n++) m_cells[k][n] = 0;
                m_turn[k] = fp[k];
                m_cnt[k] = 0;
                m_phase[k] = 0;
                m_winner[k] = 0;
                m_ack[k] = 0;
                m_err[k] = 0;
            end else begin
                int code;
                code = m_turn[k] ? 2 : 1;
                m_ack[k] = 0;
                m_err[k] = 0;
                case (m_phase[k])
                    0: if (mv_valid) begin
                        if (int'(mv_cell) > 8) m_err[k] = 1;
                        else if (m_cells[k][int'(mv_cell)] != 0) m_err[k] = 1;
                        else begin
                            m_cells[k][int'(mv_cell)] = code;
                            m_cnt[k]++;
                            m_ack[k] = 1;
                            m_phase[k] = 1;
                        end
                    end
                    1: begin
                        if (has_line(k, code)) begin
                            m_phase[k] = 2;
                            m_winner[k] = code;
                        end else if (m_cnt[k] == 9) begin
                            m_phase[k] = 3;
                            m_winner[k] = 0;
                        end else begin
                            m_turn[k] = ~m_turn[k];
                            m_phase[k] = 0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (rst) armed = 1;
    end

    task automatic chk(string name, logic [17:0] act, logic [17:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                logic [17:0] eb, ec;
                int code;
                code = m_turn[k] ? 2 : 1;
                for (int n = 0; n < 9; n++) begin
                    eb[17-2*n -: 2] = 2'(m_cells[k][n]);
                    ec[17-2*n -: 2] = (m_cells[k][n] == code) ? 2'b01 : 2'b00;
                end
                chk($sformatf("dut%0d board", k), board_w[k], eb);
                chk($sformatf("dut%0d chk_board", k), chk_w[k], ec);
                chk($sformatf("dut%0d turn", k), 18'(turn_w[k]), 18'(m_turn[k]));
                chk($sformatf("dut%0d mv_ready", k), 18'(ready_w[k]), 18'(m_phase[k] == 0));
                chk($sformatf("dut%0d mv_ack", k), 18'(ack_w[k]), 18'(m_ack[k]));
                chk($sformatf("dut%0d mv_err", k), 18'(err_w[k]), 18'(m_err[k]));
                chk($sformatf("dut%0d game_over", k), 18'(over_w[k]), 18'(m_phase[k] >= 2));
                chk($sformatf("dut%0d winner", k), 18'(winner_w[k]), 18'(m_winner[k]));
                chk($sformatf("dut%0d move_cnt", k), 18'(cnt_w[k]), 18'(m_cnt[k]));
            end
            if (ack_w[0]) ack_cnt++;
            if (err_w[0]) err_cnt++;
        end
    end

    task automatic move(int c);
        int n = 0;
        while (!ready_w[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got mv_ready=0 required 1 before cell %0d", c);
        end
        mv_valid = 1'b1;
        mv_cell = 4'(c);
        @(negedge clk);
        mv_valid = 1'b0;
    endtask

    task automatic fresh_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        ack_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic play(int seq[$]);
        foreach (seq[i]) move(seq[i]);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("lit reset board", board_w[0], 18'h0);
        chk("lit reset cnt", 18'(cnt_w[0]), 18'd0);
        chk("lit reset ready", 18'(ready_w[0]), 18'd1);
        chk("lit reset turn1", 18'(turn_w[1]), 18'd1);

        // X wins the top row (O wins it on the O-first instance)
        play('{0, 3, 1, 4, 2});
        chk("lit row board0", board_w[0], 18'b010101_101000_000000);
        chk("lit row board1", board_w[1], 18'b101010_010100_000000);
        chk("lit row winner0", 18'(winner_w[0]), 18'b01);
        chk("lit row winner1", 18'(winner_w[1]), 18'b10);
        chk("lit row over", 18'(over_w[0]), 18'd1);
        chk("lit row cnt", 18'(cnt_w[0]), 18'd5);
        chk("lit row acks", 18'(ack_cnt), 18'd5);

        // Occupied and out-of-range requests
        fresh_game();
        play('{4, 4, 12});
        chk("lit rej errs", 18'(err_cnt), 18'd2);
        chk("lit rej board", board_w[0], 18'b000000_000100_000000);
        chk("lit rej turn", 18'(turn_w[0]), 18'd1);
        chk("lit rej cnt", 18'(cnt_w[0]), 18'd1);

        // Draw, then moves are ignored
        fresh_game();
        play('{0, 1, 2, 4, 3, 5, 7, 6, 8});
        chk("lit draw over", 18'(over_w[0]), 18'd1);
        chk("lit draw winner", 18'(winner_w[0]), 18'd0);
        chk("lit draw cnt", 18'(cnt_w[0]), 18'd9);
        mv_valid = 1'b1;
        mv_cell = 4'd0;
        repeat (3) @(negedge clk);
        mv_valid = 1'b0;
        chk("lit draw ignored", 18'(ack_cnt + err_cnt), 18'd9);

        // O wins column 1; X holding 0,3,8 is no win
        fresh_game();
        play('{0, 1, 3, 4, 8});
        chk("lit col nowin", 18'(over_w[0]), 18'd0);
        play('{7});
        chk("lit col winner", 18'(winner_w[0]), 18'b10);

        // new_game with a move in PLAY, then during CHECK
        fresh_game();
        play('{0, 1});
        new_game = 1'b1;
        mv_valid = 1'b1;
        mv_cell = 4'd2;
        @(negedge clk);
        new_game = 1'b0;
        mv_valid = 1'b0;
        chk("lit ng play board", board_w[0], 18'h0);
        chk("lit ng play ack", 18'(ack_w[0]), 18'd0);
        move(0);
        new_game = 1'b1;
        mv_valid = 1'b1;
        mv_cell = 4'd5;
        @(negedge clk);
        new_game = 1'b0;
        mv_valid = 1'b0;
        chk("lit ng chk cnt", 18'(cnt_w[0]), 18'd0);
        chk("lit ng chk ready", 18'(ready_w[0]), 18'd1);

        // rst together with new_game and mv_valid
        move(6);
        rst = 1'b1;
        new_game = 1'b1;
        mv_valid = 1'b1;
        mv_cell = 4'd1;
        @(negedge clk);
        rst = 1'b0;
        new_game = 1'b0;
        mv_valid = 1'b0;
        chk("lit rst board", board_w[0], 18'h0);
        chk("lit rst turn0", 18'(turn_w[0]), 18'd0);
        move(0);
        chk("lit fp1 first", board_w[1], 18'b100000_000000_000000);
        chk("lit fp0 first", board_w[0], 18'b010000_000000_000000);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ttt_move_ctrl.md
# ttt_move_ctrl

Upstream stage of the tic-tac-toe win checker. It accepts move requests from the input and UI layer and keeps the registered 18-bit board. It alternates turns, rejects illegal moves, and presents the mover's cells to the three-in-a-row checker. It then consumes the checker's flag to decide win, draw or continue.

## Interface
- FIRST_PLAYER, default 0: player that moves first after reset or new game (0 = X, 1 = O).
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset; sampled on rising clk.
- new_game  in  1  single-cycle pulse; clears board and starts a fresh game.
- mv_valid  in  1  move request strobe.
- mv_cell  in  4  target cell 0..8; cell n occupies board[17-2n:16-2n].
- win_in  in  1  result from the three-in-a-row checker, driven combinationally from chk_board.
- board  out  18  full board; per cell 00 = empty, 01 = X, 10 = O; 11 never produced.
- chk_board  out  18  checker feed; cell = 01 where board cell belongs to the current mover, else 00.
- turn  out  1  current mover (0 = X, 1 = O).
- mv_ready  out  1  high only in PLAY.
- mv_ack  out  1  one-cycle pulse; move accepted.
- mv_err  out  1  one-cycle pulse; move rejected.
- game_over  out  1  high in WIN or DRAW.
- winner  out  2  01 = X, 10 = O, 00 = none/draw.
- move_cnt  out  4  accepted moves this game, 0..9.

## Operation
- States: PLAY, CHECK, WIN, DRAW.
- Reset or new_game: board = 0, move_cnt = 0, turn = FIRST_PLAYER, winner = 00, state = PLAY.
  - rst has priority over new_game.
  - new_game is honoured in every state, including mid-CHECK; it discards any in-flight check.
  - mv_ack and mv_err are 0 in the cycle after reset or new_game.
- PLAY with mv_valid:
  - Reject when mv_cell > 8 or the target cell is non-zero: pulse mv_err, board unchanged, stay in PLAY.
  - Otherwise accept:
    - write code {turn, ~turn} into the cell (X = 01, O = 10);
    - increment move_cnt;
    - pulse mv_ack;
    - go to CHECK.
- mv_valid outside PLAY is ignored: no ack, no err.
- mv_valid together with new_game: new_game wins, and the move is dropped.
- CHECK (exactly one cycle): chk_board reflects the board including the new move, with the mover unchanged.
  - win_in = 1 → WIN; winner = mover's code.
  - else move_cnt == 9 → DRAW; winner = 00.
  - else toggle turn → PLAY.
- WIN and DRAW: hold board, winner, move_cnt and turn; stay until new_game or rst.
- chk_board is combinational from the registered board and turn. It never shows the opponent's cells, so the occupancy-only checker reports only the mover's lines.
- move_cnt never exceeds 9. A tenth move is impossible because DRAW or WIN is entered first.

## Timing
- Move sampled at edge t (PLAY, legal) → board, move_cnt and mv_ack updated after t; state = CHECK.
- win_in sampled at edge t+1.
- After t+1: game_over/winner valid, or turn toggled and mv_ready = 1.
- Sustained throughput: one move per 2 cycles. mv_ready is low during CHECK.
- Reject: mv_err high in the cycle after the sampling edge; mv_ready stays high.
- All outputs are registered except chk_board (combinational) and mv_ready (decoded from state).
- Reset values:
  - board = 0, chk_board = 0, move_cnt = 0, winner = 00;
  - mv_ack = 0, mv_err = 0, game_over = 0;
  - turn = FIRST_PLAYER, mv_ready = 1.

## Test plan
- **X wins top row:** FIRST_PLAYER = 0; moves 0, 3, 1, 4, 2, each presented while mv_ready → five mv_ack pulses; after the fifth, state WIN with winner = 01, game_over = 1, move_cnt = 5, board = 18'b010101_101000_000000.
- **Occupied and out-of-range cells:** move 4 (X); then O requests 4, then 12 → two mv_err pulses, board unchanged, turn stays O, move_cnt = 1.
- **Draw:** moves 0, 1, 2, 4, 3, 5, 7, 6, 8 → no WIN; after the ninth, state DRAW with game_over = 1, winner = 00, move_cnt = 9. Further mv_valid is ignored.
- **O wins column 1 with a checker-correctness check:** moves 0, 1, 3, 4, 8, 7 → WIN with winner = 10 at the sixth move. No false win is reported after the fifth move (X holds 0, 3, 8).
- **new_game mid-game and during CHECK, with mv_valid asserted in the same cycle:** board = 0, move_cnt = 0, turn = FIRST_PLAYER, no mv_ack, state PLAY.
- **rst asserted with new_game and mv_valid:** all outputs take their reset values next cycle. Rerun with FIRST_PLAYER = 1 → first accepted move writes 10.
